// File: rtl/fft_reorder_if.sv
// fft_reorder_if: dual-lane input / natural-order output handshake bundle for fft_reorder.
// Ports: in_valid/in_ready with in_up_re/in_up_im/in_l_re/in_l_im (pair input),
//        out_valid/out_ready with out_re/out_im/out_index/out_last (bin output).
// slave modport = reorder block, master modport = upstream/downstream side.
interface fft_reorder_if #(parameter int WIDTH = 9);
    logic in_valid;
    logic in_ready;
    logic signed [WIDTH-1:0] in_up_re;
    logic signed [WIDTH-1:0] in_up_im;
    logic signed [WIDTH-1:0] in_l_re;
    logic signed [WIDTH-1:0] in_l_im;
    logic out_valid;
    logic out_ready;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic [4:0] out_index;
    logic out_last;
    modport master (
        output in_valid, in_up_re, in_up_im, in_l_re, in_l_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_index, out_last
    );
    modport slave (
        input  in_valid, in_up_re, in_up_im, in_l_re, in_l_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_index, out_last
    );
endinterface

// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong buffer turning 32-point MDC bit-reversed pairs into natural-order bins.
// Ports: clk, rst (async active-high), bus (fft_reorder_if.slave).
// Option: FFT_REORDER_DROP_CNT_EN adds drop_cnt[7:0], a saturating count of refused pairs.
module fft_reorder #(parameter int WIDTH = 9) (
    input logic clk,
    input logic rst,
    fft_reorder_if.slave bus
`ifdef FFT_REORDER_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_t;
    bank_t st [2];
    logic [2*WIDTH-1:0] mem [64];
    logic wptr;
    logic rptr;
    logic [3:0] wcnt;
    logic [4:0] rcnt;
    logic [3:0] wrev;
    logic acc;
    logic xfer;
    logic fin;
    logic start;
    logic chain;
    logic [5:0] raddr;
    logic [2*WIDTH-1:0] rdata;
    // bitrev5(2k) = {0, rev4(k)} and bitrev5(2k+1) = {1, rev4(k)}
    assign wrev = {wcnt[0], wcnt[1], wcnt[2], wcnt[3]};
    assign bus.in_ready = !rst && (st[wptr] == EMPTY || st[wptr] == FILLING);
    assign acc = bus.in_valid && bus.in_ready;
    assign xfer = bus.out_valid && bus.out_ready;
    assign fin = xfer && bus.out_last;
    // other bank already full at the final transfer: continue without a gap
    assign chain = fin && st[~rptr] == FULL;
    assign start = !bus.out_valid && st[rptr] == FULL;
    // rcnt holds the address of the next bin to present
    assign raddr = chain ? {~rptr, 5'd0} : start ? {rptr, 5'd0} : {rptr, rcnt};
    assign rdata = mem[raddr];
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[{wptr, 1'b0, wrev}] <= {bus.in_up_re, bus.in_up_im};
            mem[{wptr, 1'b1, wrev}] <= {bus.in_l_re, bus.in_l_im};
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st[0] <= EMPTY;
            st[1] <= EMPTY;
            wptr <= 1'b0;
            rptr <= 1'b0;
            wcnt <= 4'd0;
            rcnt <= 5'd0;
            bus.out_valid <= 1'b0;
            bus.out_re <= '0;
            bus.out_im <= '0;
            bus.out_index <= 5'd0;
            bus.out_last <= 1'b0;
        end else begin
            if (acc) begin
                st[wptr] <= (wcnt == 4'd15) ? FULL : FILLING;
                wcnt <= wcnt + 4'd1;
                if (wcnt == 4'd15) wptr <= ~wptr;
            end
            if (fin) begin
                st[rptr] <= EMPTY;
                rptr <= ~rptr;
            end
            if (start) st[rptr] <= READING;
            if (chain) st[~rptr] <= READING;
            if (start || chain || (xfer && !fin)) begin
                bus.out_valid <= 1'b1;
                bus.out_re <= rdata[2*WIDTH-1:WIDTH];
                bus.out_im <= rdata[WIDTH-1:0];
                bus.out_index <= raddr[4:0];
                bus.out_last <= &raddr[4:0];
                rcnt <= raddr[4:0] + 5'd1;
            end else if (fin) begin
                bus.out_valid <= 1'b0;
                bus.out_re <= '0;
                bus.out_im <= '0;
                bus.out_index <= 5'd0;
                bus.out_last <= 1'b0;
                rcnt <= 5'd0;
            end
        end
    end
`ifdef FFT_REORDER_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt <= 8'd0;
        else if (bus.in_valid && !bus.in_ready && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: scoreboard bench for fft_reorder (natural-order model, stall, stream, reset, drop, extremes).
module tb_fft_reorder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int nout = 0;
    int idle = 0;
    int mk = 0;
    typedef struct packed {
        logic signed [8:0] re;
        logic signed [8:0] im;
        logic [4:0] idx;
    } exp_t;
    exp_t q[$];
    logic signed [8:0] fre [32];
    logic signed [8:0] fim [32];
`ifdef FFT_REORDER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    fft_reorder_if #(.WIDTH(9)) bus();

    fft_reorder #(.WIDTH(9)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FFT_REORDER_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    // reference model: collect pairs in bit-reversed slots, release a frame in bin order
    always @(negedge clk) begin
        exp_t e;
        logic [4:0] b;
        if (rst) begin
            q.delete();
            mk = 0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                b = bitrev5(5'(2 * mk));
                fre[b] = bus.in_up_re;
                fim[b] = bus.in_up_im;
                b = bitrev5(5'(2 * mk + 1));
                fre[b] = bus.in_l_re;
                fim[b] = bus.in_l_im;
                mk++;
                if (mk == 16) begin
                    for (int n = 0; n < 32; n++) q.push_back('{re: fre[n], im: fim[n], idx: 5'(n)});
                    mk = 0;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                nout++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_output got idx=%0d re=%0d im=%0d want no output", bus.out_index, bus.out_re, bus.out_im);
                end else begin
                    e = q.pop_front();
                    if ({bus.out_re, bus.out_im, bus.out_index, bus.out_last} !== {e.re, e.im, e.idx, (e.idx == 5'd31)}) begin
                        failures++;
                        $display("FAIL out_bin got re=%0d im=%0d idx=%0d last=%0b want re=%0d im=%0d idx=%0d last=%0b",
                                 bus.out_re, bus.out_im, bus.out_index, bus.out_last, e.re, e.im, e.idx, (e.idx == 5'd31));
                    end
                end
            end
            if (!bus.out_valid) begin
                idle++;
                checks++;
                if ({bus.out_re, bus.out_im, bus.out_index, bus.out_last} !== 24'd0) begin
                    failures++;
                    $display("FAIL idle_zero got re=%0d im=%0d idx=%0d last=%0b want all 0", bus.out_re, bus.out_im, bus.out_index, bus.out_last);
                end
            end
        end
    end

    task automatic send(input logic signed [8:0] ur, ui, lr, li);
        logic r;
        bus.in_valid = 1'b1;
        bus.in_up_re = ur;
        bus.in_up_im = ui;
        bus.in_l_re = lr;
        bus.in_l_im = li;
        do begin
            r = bus.in_ready;
            @(posedge clk);
            #1;
        end while (!r);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        for (int n = 0; n < 600 && nout < target; n++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_up_re = '0;
        bus.in_up_im = '0;
        bus.in_l_re = '0;
        bus.in_l_im = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        checks++;
        if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_index, bus.out_last} !== 25'd0) begin
            failures++;
            $display("FAIL rst_outputs got v=%b re=%0d im=%0d idx=%0d last=%b want all 0", bus.out_valid, bus.out_re, bus.out_im, bus.out_index, bus.out_last);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int base = nout;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) send(9'(2 * k), -9'(2 * k), 9'(2 * k + 1), -9'(2 * k + 1));
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got out_valid=%b want 0", bus.out_valid); end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_index, bus.out_re} !== {1'b1, 5'd0, 9'sd0}) begin
            failures++;
            $display("FAIL latency_bin0 got v=%b idx=%0d re=%0d want v=1 idx=0 re=0", bus.out_valid, bus.out_index, bus.out_re);
        end
        wait_out(base + 32);
        checks++;
        if (nout !== base + 32) begin failures++; $display("FAIL basic_count got %0d want %0d", nout - base, 32); end
    endtask

    task automatic test_stream();
        int base = nout;
        time t32 = 0;
        time t48 = 0;
        int i0 = 0;
        bus.out_ready = 1'b1;
        fork
            for (int p = 0; p < 64; p++) begin
                send(9'(p * 2), -9'(p * 2), 9'(p * 2 + 1), -9'(p * 2 + 1));
                if (p == 32) t32 = $time;
                if (p == 48) t48 = $time;
            end
            begin
                for (int n = 0; n < 100 && !bus.out_valid; n++) begin
                    @(posedge clk);
                    #1;
                end
                i0 = idle;
                wait_out(base + 128);
            end
        join
        checks++;
        if (t48 - t32 !== 320) begin failures++; $display("FAIL stream_ready_duty got %0d want 320 time units per frame", t48 - t32); end
        checks++;
        if (nout !== base + 128) begin failures++; $display("FAIL stream_count got %0d want 128", nout - base); end
        checks++;
        if (idle !== i0) begin failures++; $display("FAIL stream_gapless got %0d idle cycles want 0", idle - i0); end
    endtask

    task automatic test_stall();
        int base = nout;
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic sv;
        logic sr;
        logic [23:0] snap;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(9'(3 * k), 9'(k - 50), 9'(3 * k + 100), 9'(-k));
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_index} !== {1'b1, 5'd0}) begin
            failures++;
            $display("FAIL stall_hold_bin0 got v=%b idx=%0d want v=1 idx=0", bus.out_valid, bus.out_index);
        end
        for (int i = 0; i < 200 && nout < base + 32; i++) begin
            bus.out_ready = pat[i % 4];
            sv = bus.out_valid;
            sr = bus.out_ready;
            snap = {bus.out_re, bus.out_im, bus.out_index, bus.out_last};
            @(posedge clk);
            #1;
            if (sv && !sr) begin
                checks++;
                if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_index, bus.out_last} !== {1'b1, snap}) begin
                    failures++;
                    $display("FAIL stall_stable got %h want %h", {bus.out_re, bus.out_im, bus.out_index, bus.out_last}, snap);
                end
            end
        end
        bus.out_ready = 1'b1;
        checks++;
        if (nout !== base + 32) begin failures++; $display("FAIL stall_count got %0d want 32", nout - base); end
    endtask

    task automatic test_reset_mid();
        int base;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) send(9'(77), 9'(-77), 9'(78), 9'(-78));
        for (int k = 0; k < 8; k++) send(9'(99), 9'(-99), 9'(98), 9'(-98));
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got %b want 0", bus.in_ready); end
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_release got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        base = nout;
        for (int k = 0; k < 16; k++) send(9'(-k), 9'(k), 9'(-k - 20), 9'(k + 20));
        wait_out(base + 32);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (nout !== base + 32) begin failures++; $display("FAIL mid_rst_count got %0d want 32", nout - base); end
    endtask

    task automatic test_drop();
        int base;
        int stalled = 0;
        pulse_rst();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 32; k++) send(9'(k + 5), 9'(-k - 5), 9'(k + 60), 9'(-k - 60));
        bus.in_valid = 1'b1;
        bus.in_up_re = 9'sd1;
        for (int c = 0; c < 5; c++) begin
            if (!bus.in_ready) stalled++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (stalled !== 5) begin failures++; $display("FAIL drop_ready_low got %0d cycles want 5", stalled); end
`ifdef FFT_REORDER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd5) begin failures++; $display("FAIL drop_cnt_5 got %0d want 5", drop_cnt); end
`endif
        base = nout;
        bus.out_ready = 1'b1;
        wait_out(base + 64);
        checks++;
        if (nout !== base + 64) begin failures++; $display("FAIL drop_buffered got %0d want 64", nout - base); end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 32; k++) send(9'(-k), 9'(-k), 9'(k), 9'(k));
        bus.in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
`ifdef FFT_REORDER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_cnt_sat got %0d want 255", drop_cnt); end
`endif
        base = nout;
        bus.out_ready = 1'b1;
        wait_out(base + 64);
        checks++;
        if (nout !== base + 64) begin failures++; $display("FAIL drop_drain got %0d want 64", nout - base); end
    endtask

    task automatic test_extreme();
        int base = nout;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) send(9'sd255, -9'sd256, 9'sd255, -9'sd256);
        @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_re, bus.out_im} !== {1'b1, 9'sd255, -9'sd256}) begin
            failures++;
            $display("FAIL extreme_bin0 got v=%b re=%0d im=%0d want v=1 re=255 im=-256", bus.out_valid, bus.out_re, bus.out_im);
        end
        wait_out(base + 32);
        checks++;
        if (nout !== base + 32) begin failures++; $display("FAIL extreme_count got %0d want 32", nout - base); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_stall();
        test_reset_mid();
        test_drop();
        test_extreme();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q.size() !== 0) begin failures++; $display("FAIL leftover_expected got %0d want 0", q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 WIDTH, default 9, sample component width (signed two's complement).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  dual-lane input pair present this cycle.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 in_up_re / in_up_im  input  WIDTH each  upper-lane sample from final MDC stage.
REQ-007 in_l_re / in_l_im  input  WIDTH each  lower-lane sample from final MDC stage.
REQ-008 out_valid  output  1  natural-order sample present.
REQ-009 out_ready  input  1  downstream accepts the sample.
REQ-010 out_re / out_im  output  WIDTH each  output sample.
REQ-011 out_index  output  5  bin number of the output sample, 0..31.
REQ-012 out_last  output  1  high with bin 31.

Function
REQ-013 Frame = 16 accepted input pairs (32 bins); a pair is accepted when in_valid && in_ready.
REQ-014 Pair k (0..15) of a frame: up lane = bin bitrev5(2k); lower lane = bin bitrev5(2k+1); both written to the current write bank in the accepting cycle.
REQ-015 Storage: two 32-entry banks (ping-pong), each 2*WIDTH bits; each bank state is EMPTY, FILLING, FULL or READING.
REQ-016 Write side: write counter wcnt[3:0] increments per accepted pair; on wcnt==15 accept, bank -> FULL, write pointer toggles, wcnt -> 0.
REQ-017 in_ready = 1 iff the write-pointer bank is EMPTY or FILLING; a bank that is FULL or READING blocks in_ready.
REQ-018 in_valid while in_ready==0: pair dropped, no state change.
REQ-019 Read side: when the read-pointer bank is FULL, it becomes READING next cycle and out_valid rises that cycle.
REQ-020 Output emits bins 0..31 in ascending order, one per cycle when out_ready=1; registered output, out_re/out_im/out_index/out_last stable while out_valid && !out_ready.
REQ-021 Transfer on out_valid && out_ready; after the bin-31 transfer the bank becomes EMPTY and the read pointer toggles; if the other bank is FULL, out_valid stays high with no gap (bin 0 of the next frame in the next cycle).
REQ-022 Latency: with out_ready=1, bin 0 appears 2 cycles after the cycle accepting pair 15.
REQ-023 Simultaneous write of the last pair into bank A and final read of bank B in the same cycle: both take effect; no pair lost, no duplicate output.
REQ-024 Continuous input at 1 pair/cycle: throughput limited to 1 frame per 32 cycles via in_ready; no data corruption.
REQ-025 out_valid, out_re, out_im, out_index, out_last are 0 whenever no sample is presented.

Reset
REQ-026 rst asserted: both banks EMPTY, wcnt=0, read counter=0, pointers=bank 0, in_ready=0 during reset, out_valid=0, out_re=out_im=0, out_index=0, out_last=0.
REQ-027 in_ready=1 first clock edge after rst deasserts.
REQ-028 Reset mid-frame or mid-read discards all partial and buffered frames; bank memory contents need not be cleared.

Configuration
REQ-029 Macro FFT_REORDER_DROP_CNT_EN defined: extra output drop_cnt (8 bits), incremented for each REQ-018 dropped pair, saturating at 255, cleared by rst.
REQ-030 Macro undefined: no drop_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-031 Pair k = (up: re=2k, im=-2k; l: re=2k+1, im=-(2k+1)), 16 pairs back-to-back, out_ready=1 -> bin n emitted in order 0..31 with re=bitrev5(n), im=-bitrev5(n); out_last on n=31; bin 0 two cycles after pair 15.
REQ-032 Four frames streamed with in_valid=1 every cycle -> in_ready low 16 of every 32 cycles in steady state, 128 outputs correct, out_valid gapless after first frame.
REQ-033 out_ready toggled 1,0,0,1 repeating -> output values held during stall, no bin skipped or repeated.
REQ-034 rst pulsed after pair 7 of frame 1 -> out_valid=0, in_ready=1 after release; next full frame outputs only new data.
REQ-035 Both banks full, in_valid=1 for 5 cycles with in_ready=0 -> with FFT_REORDER_DROP_CNT_EN drop_cnt=5; buffered frames unaffected; 300 drops -> drop_cnt=255.
REQ-036 Extreme values: all inputs re=255, im=-256 (WIDTH=9) -> outputs exactly 255/-256, no sign corruption.
